// File: rtl/bf16_dot_accumulator_pkg.sv
// Shared constants, types and helpers for the bf16 dot-product accumulator.
package bf16_dot_accumulator_pkg;

  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int unsigned OFIFO_D = 2;

  localparam int unsigned BF16_W  = 16;
  localparam int unsigned FP32_W  = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [FP32_W-1:0] FP32_PINF = 32'h7F80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // bf16 is the top half of an fp32, so widening is exact.
  function automatic logic [FP32_W-1:0] bf16_to_fp32(input logic [BF16_W-1:0] h);
    return {h, {(FP32_W - BF16_W){1'b0}}};
  endfunction

endpackage

// File: rtl/bf16_dot_accumulator_if.sv
// Input partial-sum stream and output result handshake of the accumulator.
interface bf16_dot_accumulator_if;
  import bf16_dot_accumulator_pkg::*;

  logic [BF16_W-1:0] din;
  logic              din_valid;
  logic [LEN_W-1:0]  cfg_len;
  logic [FP32_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output din, din_valid, cfg_len, dout_ready,
    input  dout, dout_valid
  );

  modport slave (
    input  din, din_valid, cfg_len, dout_ready,
    output dout, dout_valid
  );

endinterface

// File: rtl/bf16_dot_accumulator_fp32_adder.sv
// Combinational FP32 adder: RNE rounding, flush-to-zero, IEEE-style specials.
module bf16_dot_accumulator_fp32_adder
  import bf16_dot_accumulator_pkg::*;
(
  input  logic [FP32_W-1:0] a_i,
  input  logic [FP32_W-1:0] b_i,
  output logic [FP32_W-1:0] sum_o
);

  fp32_t             a, b, big, sml;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              swap, sticky, rnd_up;
  logic [EXP_W-1:0]  diff;
  logic [26:0]       mb, ms;
  logic [27:0]       m;
  logic [4:0]        msb, lsh;
  logic signed [9:0] e;
  logic [24:0]       mr;
  logic [MAN_W-1:0]  frac;

  // Align, add/subtract, normalise, round, then let special operands override.
  always_comb begin
    a      = fp32_t'(a_i);
    b      = fp32_t'(b_i);
    a_nan  = (a.exp == '1) && (a.man != '0);
    b_nan  = (b.exp == '1) && (b.man != '0);
    a_inf  = (a.exp == '1) && (a.man == '0);
    b_inf  = (b.exp == '1) && (b.man == '0);
    a_zero = (a.exp == '0);
    b_zero = (b.exp == '0);

    swap = {b.exp, b.man} > {a.exp, a.man};
    big  = swap ? b : a;
    sml  = swap ? a : b;
    diff = big.exp - sml.exp;

    // Three guard bits; everything shifted further collapses into bit 0.
    mb     = {1'b1, big.man, 3'b000};
    ms     = {1'b1, sml.man, 3'b000};
    sticky = 1'b0;
    if (diff >= 8'd27) begin
      sticky = 1'b1;
      ms     = '0;
    end else begin
      for (int unsigned i = 0; i < 27; i++) begin
        if (i < 32'(diff)) sticky = sticky | ms[i];
      end
      ms = ms >> diff;
    end
    ms[0] = ms[0] | sticky;

    if (big.sign == sml.sign) m = {1'b0, mb} + {1'b0, ms};
    else                      m = {1'b0, mb} - {1'b0, ms};

    e   = signed'({2'b00, big.exp});
    msb = '0;
    lsh = '0;
    if (m[27]) begin
      m = {1'b0, m[27:2], m[1] | m[0]};
      e = e + 10'sd1;
    end else begin
      for (int unsigned i = 0; i < 27; i++) begin
        if (m[i]) msb = 5'(i);
      end
      lsh = 5'd26 - msb;
      m   = m << lsh;
      e   = e - signed'({5'b00000, lsh});
    end

    rnd_up = m[2] & (m[1] | m[0] | m[3]);
    mr     = {1'b0, m[26:3]} + {24'b0, rnd_up};
    if (mr[24]) begin
      frac = mr[23:1];
      e    = e + 10'sd1;
    end else begin
      frac = mr[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a.sign != b.sign))) sum_o = FP32_QNAN;
    else if (a_inf)                sum_o = a_i;
    else if (b_inf)                sum_o = b_i;
    else if (a_zero && b_zero)     sum_o = {a.sign & b.sign, 31'b0};
    else if (a_zero)               sum_o = b_i;
    else if (b_zero)               sum_o = a_i;
    else if (m == '0)              sum_o = '0;
    else if (e >= 10'sd255)        sum_o = FP32_PINF | {big.sign, 31'b0};
    else if (e <= 10'sd0)          sum_o = {big.sign, 31'b0};
    else                           sum_o = {big.sign, e[7:0], frac};
  end

endmodule

// File: rtl/bf16_dot_accumulator.sv
// Sums groups of cfg_len bf16 partials into FP32 results behind a 2-entry FIFO.
module bf16_dot_accumulator
  import bf16_dot_accumulator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  bf16_dot_accumulator_if.slave bus,
  output logic                  busy,
  output logic                  err_overflow
);

  state_e            state_q;
  logic [LEN_W-1:0]  cnt_q, len_q;
  logic [FP32_W-1:0] acc_q;
  logic              busy_q;
  logic [FP32_W-1:0] beat_fp32, sum;
  logic              len_one, last_beat;
  logic              push_d, pop_d;
  logic [FP32_W-1:0] push_data_d;
  logic [FP32_W-1:0] fifo_q [OFIFO_D];
  logic [1:0]        count_q;
  logic              err_q;

  assign beat_fp32 = bf16_to_fp32(bus.din);
  assign len_one   = (bus.cfg_len <= LEN_W'(1));
  assign last_beat = (state_q == ST_ACCUM) && (cnt_q == len_q - LEN_W'(1));
  assign pop_d     = bus.dout_ready && (count_q != '0);

  bf16_dot_accumulator_fp32_adder u_add (
    .a_i   (acc_q),
    .b_i   (beat_fp32),
    .sum_o (sum)
  );

  // A beat completes a group either as a length-1 group or as the last ACCUM beat.
  always_comb begin
    push_d      = 1'b0;
    push_data_d = sum;
    if (bus.din_valid) begin
      if (state_q == ST_IDLE) begin
        push_d      = len_one;
        push_data_d = beat_fp32;
      end else begin
        push_d = last_beat;
      end
    end
  end

  // Group FSM: bubbles (din_valid=0) leave every register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
    end else if (bus.din_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          acc_q <= beat_fp32;
          len_q <= len_one ? LEN_W'(1) : bus.cfg_len;
          cnt_q <= LEN_W'(1);
          if (!len_one) begin
            state_q <= ST_ACCUM;
            busy_q  <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (last_beat) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= sum;
            cnt_q <= cnt_q + LEN_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output FIFO: slot 0 is the registered head; a push into a full FIFO without a pop is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q  <= '{default: '0};
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case ({push_d, pop_d})
        2'b10: begin
          if (count_q == 2'(OFIFO_D)) begin
            err_q <= 1'b1;
          end else begin
            fifo_q[count_q[0]] <= push_data_d;
            count_q            <= count_q + 2'd1;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) fifo_q[0] <= fifo_q[1];
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= push_data_d;
          end else begin
            fifo_q[0] <= push_data_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout       = fifo_q[0];
  assign bus.dout_valid = (count_q != '0);
  assign busy           = busy_q;
  assign err_overflow   = err_q;

endmodule

// File: tb/tb_bf16_dot_accumulator.sv
// Scoreboard bench: real-arithmetic reference model, decoupled output monitor.
module tb_bf16_dot_accumulator;
  import bf16_dot_accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy, err_overflow;

  bf16_dot_accumulator_if bus ();

  bf16_dot_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  bit          m_in_grp = 1'b0;
  int unsigned m_len    = 0;
  int unsigned m_cnt    = 0;
  logic [31:0] m_sum    = '0;
  int unsigned m_fifo   = 0;
  bit          m_err    = 1'b0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic real to_real(input logic [31:0] f);
    real v;
    int  ex;
    if (f[30:23] == 8'h00) return 0.0;
    v  = 1.0 + real'(f[22:0]) / 8388608.0;
    ex = int'(f[30:23]) - 127;
    while (ex > 0) begin v = v * 2.0; ex--; end
    while (ex < 0) begin v = v / 2.0; ex++; end
    return f[31] ? -v : v;
  endfunction

  // Round a nonzero real to fp32 (RNE), saturating to Inf and flushing tiny values.
  function automatic logic [31:0] from_real(input real x);
    logic       s;
    real        ax, fr, fl;
    int         ex, be;
    longint     mant;
    logic [7:0] be8;
    s  = (x < 0.0);
    ax = s ? -x : x;
    ex = 0;
    while (ax >= 2.0) begin ax = ax / 2.0; ex++; end
    while (ax < 1.0)  begin ax = ax * 2.0; ex--; end
    fr   = ax * 8388608.0;
    fl   = $floor(fr);
    mant = longint'(fl);
    if ((fr - fl) > 0.5 || ((fr - fl) == 0.5 && mant[0])) mant++;
    if (mant == 64'd16777216) begin mant = 64'd8388608; ex++; end
    be = ex + 127;
    if (be >= 255) return {s, 8'hFF, 23'h0};
    if (be <= 0)   return {s, 31'h0};
    be8 = 8'(be);
    return {s, be8, mant[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    bit  an, bn, ai, bi, az, bz;
    real s;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn) return 32'h7FC00000;
    if (ai && bi) return (a[31] == b[31]) ? a : 32'h7FC00000;
    if (ai) return a;
    if (bi) return b;
    if (az && bz) return {a[31] & b[31], 31'h0};
    s = to_real(a) + to_real(b);
    if (s == 0.0) return 32'h0;
    return from_real(s);
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [7:0] ex;
    logic [6:0] mn;
    if ($urandom_range(0, 99) < 3) begin
      case ($urandom_range(0, 7))
        0: return 16'h7F80;
        1: return 16'hFF80;
        2: return 16'h7FC0;
        3: return 16'h0000;
        4: return 16'h8000;
        5: return 16'h0041;
        6: return 16'h7F7F;
        default: return 16'h0080;
      endcase
    end
    ex = 8'($urandom_range(118, 136));
    if ($urandom_range(0, 99) < 3) ex = 8'($urandom_range(1, 254));
    mn = 7'($urandom);
    return {1'($urandom), ex, mn};
  endfunction

  function automatic int unsigned rand_len();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 10) return 0;
    if (r < 85) return $urandom_range(1, 6);
    return $urandom_range(7, 40);
  endfunction

  // Apply one cycle of stimulus, then advance the model on the sampling edge.
  task automatic drive(input bit v, input logic [15:0] d, input int unsigned len, input bit rdy);
    bit          push, pop;
    logic [31:0] pv;
    bus.din_valid  = v;
    bus.din        = d;
    bus.cfg_len    = LEN_W'(len);
    bus.dout_ready = rdy;
    @(posedge clk);
    pop  = rdy && (m_fifo > 0);
    push = 1'b0;
    pv   = '0;
    if (v) begin
      if (!m_in_grp) begin
        m_len = (len == 0) ? 1 : len;
        m_sum = {d, 16'h0000};
        m_cnt = 1;
        if (m_len == 1) begin push = 1'b1; pv = m_sum; end
        else m_in_grp = 1'b1;
      end else begin
        m_sum = fp_add(m_sum, {d, 16'h0000});
        m_cnt++;
        if (m_cnt == m_len) begin push = 1'b1; pv = m_sum; m_in_grp = 1'b0; end
      end
    end
    if (pop) m_fifo--;
    if (push) begin
      if (m_fifo == OFIFO_D) m_err = 1'b1;
      else begin exp_q.push_back(pv); m_fifo++; end
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 16'h0000, 0, rdy);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    @(posedge clk);
    m_in_grp = 1'b0;
    m_fifo   = 0;
    m_err    = 1'b0;
    exp_q.delete();
    #1 rst = 1'b0;
  endtask

  // Monitor: every cycle compare status flags, and pop/compare on each transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_fifo > 0));
        chk("busy", 32'(busy), 32'(m_in_grp));
        chk("err_overflow", 32'(err_overflow), 32'(m_err));
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dout_unexpected: got %08h expected no result at %0t", bus.dout, $time);
          end else begin
            chk("dout", bus.dout, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.cfg_len    = '0;
    bus.dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_valid", 32'(bus.dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err_overflow), 32'h0);
    mon_en = 1'b1;

    // 16 x 1.0 back to back
    for (int i = 0; i < 16; i++) drive(1'b1, 16'h3F80, 16, 1'b1);
    chk("t1_valid", 32'(bus.dout_valid), 32'h1);
    chk("t1_dout", bus.dout, 32'h41800000);
    idle(1'b1);

    // cfg_len=0 acts as length 1
    drive(1'b1, 16'h4040, 0, 1'b1);
    chk("t2_dout", bus.dout, 32'h40400000);
    chk("t2_busy", 32'(busy), 32'h0);
    idle(1'b1);

    // +Inf + -Inf
    drive(1'b1, 16'h7F80, 2, 1'b1);
    drive(1'b1, 16'hFF80, 2, 1'b1);
    chk("t3_dout", bus.dout, 32'h7FC00000);
    idle(1'b1);

    // overflow with consumer stalled
    drive(1'b1, 16'h3F80, 1, 1'b0);
    drive(1'b1, 16'h4000, 1, 1'b0);
    drive(1'b1, 16'h4080, 1, 1'b0);
    idle(1'b0);
    chk("t4_err", 32'(err_overflow), 32'h1);
    chk("t4_head", bus.dout, 32'h3F800000);
    idle(1'b1);
    chk("t4_second", bus.dout, 32'h40000000);
    idle(1'b1);
    idle(1'b1);

    // reset mid-group discards the partial sum
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h3F80, 8, 1'b1);
    do_reset();
    drive(1'b1, 16'h3F80, 2, 1'b1);
    drive(1'b1, 16'h3F80, 2, 1'b1);
    chk("t5_dout", bus.dout, 32'h40000000);
    idle(1'b1);

    // bubbles inside a group; 1 + -1 cancels to +0
    drive(1'b1, 16'h3F80, 4, 1'b1);
    drive(1'b1, 16'hBF80, 4, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t6_busy", 32'(busy), 32'h1);
    drive(1'b1, 16'h3F00, 4, 1'b1);
    drive(1'b1, 16'h3F00, 4, 1'b1);
    chk("t6_dout", bus.dout, 32'h3F800000);
    idle(1'b1);

    // largest supported group
    for (int i = 0; i < 256; i++) drive(1'b1, 16'h3F80, 256, 1'b1);
    chk("tmax_dout", bus.dout, 32'h43800000);
    idle(1'b1);

    // randomized traffic, cfg_len re-randomized every beat
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 80, rand_bf16(), rand_len(), $urandom_range(0, 99) < 70);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) idle(1'b1);
    chk("drain", 32'(exp_q.size()), 32'h0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
